trap_controller: RTL and testbench

Supervisor trap controller for the pipelined RISC-V core. It consumes the exception request raised by the decode stage and holds the sepc, scause, stvec and sscratch CSRs. On a trap it drains and flushes the pipeline, then redirects fetch to the handler. On SRET it redirects fetch back to the saved PC.

---
 rtl/trap_controller.sv | 190 +++++++++++++++++++
 tb/tb_trap_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller: supervisor trap controller for the pipelined RISC-V core.
// It holds the stvec, sscratch, sepc and scause CSRs and accepts trap requests
// from decode. On a trap it drains and flushes the pipeline, then redirects
// fetch to stvec. On SRET it redirects fetch back to sepc.
//
// Optional feature: define TRAP_NESTED_EN so that a trap taken while the
// handler runs re-captures sepc/scause and re-enters the drain. Without it,
// such a trap is a double fault and the core halts until reset.
//
// Ports:
//   clk, reset          core clock; asynchronous active-low reset
//   exc_valid/cause/pc  trap request, cause code and faulting PC from decode
//   sret_valid          SRET decoded in the decode stage
//   csr_we/addr/wdata   CSR write port
//   csr_rdata           combinational CSR read data (pre-write values)
//   flush, stall_fetch  pipeline kill and PC hold
//   redirect_valid/pc   one-cycle fetch redirect strobe and target
//   in_handler, halted  handler executing; core stopped on double fault
module trap_controller #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] HANDLER_BASE = 64'h0000_0000_0000_1000,
  parameter int unsigned     DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_valid,
  input  logic [31:0]     exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            sret_valid,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            flush,
  output logic            stall_fetch,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            in_handler,
  output logic            halted
);

  localparam logic [11:0] ADDR_STVEC    = 12'h105;
  localparam logic [11:0] ADDR_SSCRATCH = 12'h140;
  localparam logic [11:0] ADDR_SEPC     = 12'h141;
  localparam logic [11:0] ADDR_SCAUSE   = 12'h142;
  localparam logic [3:0]  DRAIN_LD      = 4'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DRAIN, ST_REDIRECT, ST_HANDLER, ST_RETURN, ST_HALT
  } state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] stvec_q, stvec_d;
  logic [XLEN-1:0] sscratch_q, sscratch_d;
  logic [XLEN-1:0] sepc_q, sepc_d;
  logic [31:0]     scause_q, scause_d;
  logic            flush_q, stall_q, redirect_valid_q, in_handler_q, halted_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            capture;

  // Trap capture owns sepc/scause this cycle; a same-cycle software write to
  // either is dropped, while writes to the other CSRs still land.
  always_comb begin
    capture    = exc_valid && (state_q == ST_IDLE || state_q == ST_HANDLER);
    stvec_d    = stvec_q;
    sscratch_d = sscratch_q;
    sepc_d     = sepc_q;
    scause_d   = scause_q;
    if (csr_we) begin
      unique case (csr_addr)
        ADDR_STVEC:    stvec_d    = {csr_wdata[XLEN-1:2], 2'b00};
        ADDR_SSCRATCH: sscratch_d = csr_wdata;
        ADDR_SEPC:     if (!capture) sepc_d = {csr_wdata[XLEN-1:2], 2'b00};
        ADDR_SCAUSE:   if (!capture) scause_d = csr_wdata[31:0];
        default: ;
      endcase
    end
    if (capture) begin
      sepc_d = exc_pc;
`ifdef TRAP_NESTED_EN
      scause_d = exc_cause;
`else
      scause_d = (state_q == ST_HANDLER) ? 32'h8000_00FF : exc_cause;
`endif
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_addr)
      ADDR_STVEC:    csr_rdata = stvec_q;
      ADDR_SSCRATCH: csr_rdata = sscratch_q;
      ADDR_SEPC:     csr_rdata = sepc_q;
      ADDR_SCAUSE:   csr_rdata = {{(XLEN-32){1'b0}}, scause_q};
      default: ;
    endcase
  end

  // Redirect targets come from the _d values so a CSR write sampled on the
  // edge entering REDIRECT/RETURN is already reflected in the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      stvec_q          <= HANDLER_BASE;
      sscratch_q       <= '0;
      sepc_q           <= '0;
      scause_q         <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      in_handler_q     <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      stvec_q          <= stvec_d;
      sscratch_q       <= sscratch_d;
      sepc_q           <= sepc_d;
      scause_q         <= scause_d;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      in_handler_q     <= 1'b0;
      halted_q         <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (exc_valid) begin
            state_q <= ST_DRAIN;
            cnt_q   <= DRAIN_LD;
            flush_q <= 1'b1;
            stall_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == 4'd1) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= stvec_d;
            flush_q          <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            flush_q <= 1'b1;
            stall_q <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          state_q      <= ST_HANDLER;
          in_handler_q <= 1'b1;
        end
        ST_HANDLER: begin
          if (exc_valid) begin
`ifdef TRAP_NESTED_EN
            state_q <= ST_DRAIN;
            cnt_q   <= DRAIN_LD;
            flush_q <= 1'b1;
            stall_q <= 1'b1;
`else
            state_q  <= ST_HALT;
            stall_q  <= 1'b1;
            halted_q <= 1'b1;
`endif
          end else if (sret_valid) begin
            state_q          <= ST_RETURN;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= sepc_d;
            flush_q          <= 1'b1;
          end else begin
            in_handler_q <= 1'b1;
          end
        end
        ST_RETURN: state_q <= ST_IDLE;
        ST_HALT: begin
          stall_q  <= 1'b1;
          halted_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign flush          = flush_q;
  assign stall_fetch    = stall_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign in_handler     = in_handler_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;
  localparam int D    = 3;
  localparam int MAXC = 4096;
  localparam logic [63:0] HB = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_cause = '0;
  logic [63:0] exc_pc = '0;
  logic        sret_valid = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic [63:0] csr_rdata;
  logic        flush, stall_fetch, redirect_valid, in_handler, halted;
  logic [63:0] redirect_pc;

  trap_controller #(.XLEN(64), .HANDLER_BASE(HB), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .sret_valid(sret_valid), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .flush(flush), .stall_fetch(stall_fetch), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .in_handler(in_handler), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [63:0] pc;
  } redir_t;
  redir_t rq[$];

  // Expected per-cycle levels, indexed by cycle number
  bit ef[MAXC];
  bit es[MAXC];
  bit eh[MAXC];
  bit ex[MAXC];

  logic [63:0] m_stvec, m_sepc, m_sscratch;
  logic [31:0] m_scause;
  int hs, idle_from, halt_from, pend_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic void setr(int which, int from, int to, bit v);
    for (int i = from; i <= to && i < MAXC; i++) begin
      case (which)
        0: ef[i] = v;
        1: es[i] = v;
        2: eh[i] = v;
        default: ex[i] = v;
      endcase
    end
  endfunction

  function automatic void model_reset();
    m_stvec = HB; m_sepc = '0; m_sscratch = '0; m_scause = '0;
    hs = -1; idle_from = 0; halt_from = -1; pend_c = -1;
  endfunction

  // 0 idle, 1 drain/redirect/return, 2 handler, 3 halted
  function automatic int phase(int c);
    if (halt_from >= 0 && c >= halt_from) return 3;
    if (hs >= 0 && c >= hs) return 2;
    if (c >= idle_from) return 0;
    return 1;
  endfunction

  function automatic logic [63:0] rd(logic [11:0] a);
    case (a)
      12'h105: return m_stvec;
      12'h140: return m_sscratch;
      12'h141: return m_sepc;
      12'h142: return {32'h0, m_scause};
      default: return '0;
    endcase
  endfunction

  // One cycle of stimulus, starting and ending on a falling edge
  task automatic step(bit exc, logic [31:0] cause, logic [63:0] pc, bit sret,
                      bit we, logic [11:0] a, logic [63:0] wd);
    int c;
    int ph;
    bit cap;
    c = cyc;
    exc_valid = exc; exc_cause = cause; exc_pc = pc; sret_valid = sret;
    csr_we = we; csr_addr = a; csr_wdata = wd;
    #1;
    chk("csr_rdata", csr_rdata, rd(a));
    ph  = phase(c);
    cap = exc && (ph == 0 || ph == 2);
    if (we) begin
      case (a)
        12'h105: m_stvec = wd & ~64'h3;
        12'h140: m_sscratch = wd;
        12'h141: if (!cap) m_sepc = wd & ~64'h3;
        12'h142: if (!cap) m_scause = wd[31:0];
        default: ;
      endcase
    end
    if (cap) begin
      m_sepc = pc;
      m_scause = cause;
      if (ph == 2) setr(2, c + 1, MAXC - 1, 1'b0);
`ifndef TRAP_NESTED_EN
      if (ph == 2) begin
        m_scause = 32'h8000_00FF;
        halt_from = c + 1;
        hs = -1;
        setr(1, c + 1, MAXC - 1, 1'b1);
        setr(3, c + 1, MAXC - 1, 1'b1);
      end else
`endif
      begin
        setr(0, c + 1, c + D + 1, 1'b1);
        setr(1, c + 1, c + D, 1'b1);
        pend_c = c + D + 1;
        hs = c + D + 2;
        idle_from = 2 * MAXC;
        setr(2, hs, MAXC - 1, 1'b1);
      end
    end else if (sret && ph == 2) begin
      setr(2, c + 1, MAXC - 1, 1'b0);
      setr(0, c + 1, c + 1, 1'b1);
      rq.push_back('{c + 1, m_sepc});
      hs = -1;
      idle_from = c + 2;
    end
    if (pend_c == c + 1) begin
      rq.push_back('{c + 1, m_stvec});
      pend_c = -1;
    end
    @(negedge clk);
    exc_valid = 1'b0; sret_valid = 1'b0; csr_we = 1'b0;
  endtask

  task automatic idle_step(logic [11:0] a);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, a, 64'h0);
  endtask

  task automatic do_reset(int hold);
    int c;
    c = cyc;
    reset = 1'b0; exc_valid = 1'b0; sret_valid = 1'b0; csr_we = 1'b0;
    #1;
    chk("rst_flush", 64'(flush), 64'h0);
    chk("rst_stall", 64'(stall_fetch), 64'h0);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'h0);
    chk("rst_redirect_pc", redirect_pc, 64'h0);
    chk("rst_in_handler", 64'(in_handler), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    model_reset();
    for (int w = 0; w < 4; w++) setr(w, c + 1, MAXC - 1, 1'b0);
    rq.delete();
    repeat (hold) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: level checks every cycle, redirect pulses against the queue
  initial begin
    redir_t r;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc < MAXC) begin
        chk("flush", 64'(flush), 64'(ef[cyc]));
        chk("stall_fetch", 64'(stall_fetch), 64'(es[cyc]));
        chk("in_handler", 64'(in_handler), 64'(eh[cyc]));
        chk("halted", 64'(halted), 64'(ex[cyc]));
      end
      if (rq.size() > 0 && rq[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL redirect_missing: actual=none expected=cycle %0d pc %h", rq[0].c, rq[0].pc);
        void'(rq.pop_front());
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL redirect_spurious (cycle %0d): actual=%h expected=no redirect", cyc, redirect_pc);
        end else begin
          r = rq.pop_front();
          chk("redirect_cycle", 64'(cyc), 64'(r.c));
          chk("redirect_pc", redirect_pc, r.pc);
        end
      end
    end
  end

  initial begin
    logic [11:0] a;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset values
    idle_step(12'h105); idle_step(12'h140); idle_step(12'h141);
    idle_step(12'h142); idle_step(12'h7C0);

    // Basic trap, ignored inputs during drain, sepc rewrite, SRET
    step(1'b1, 32'd2, 64'h80, 1'b0, 1'b0, 12'h141, 64'h0);
    step(1'b1, 32'd9, 64'h900, 1'b1, 1'b0, 12'h142, 64'h0);
    repeat (D) idle_step(12'h141);
    idle_step(12'h142);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 12'h141, 64'h84);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 12'h141, 64'h0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 12'h141, 64'h0);
    repeat (2) idle_step(12'h141);

    // Capture beats a same-cycle sepc write
    step(1'b1, 32'd7, 64'h200, 1'b0, 1'b1, 12'h141, 64'h999);
    repeat (D + 1) idle_step(12'h141);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 12'h142, 64'h0);
    repeat (2) idle_step(12'h142);

    // Same-cycle stvec write proceeds and is masked
    step(1'b1, 32'd5, 64'h300, 1'b0, 1'b1, 12'h105, 64'h3003);
    repeat (D + 1) idle_step(12'h105);

    // Trap while in the handler: nested re-entry or double fault
    step(1'b1, 32'd9, 64'h444, 1'b0, 1'b0, 12'h142, 64'h0);
    repeat (D + 3) idle_step(12'h142);
    idle_step(12'h141);
    do_reset(2);

    // Reset during drain
    step(1'b1, 32'd3, 64'h500, 1'b0, 1'b1, 12'h105, 64'h7777);
    idle_step(12'h105);
    do_reset(2);
    idle_step(12'h105);
    idle_step(12'h141);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0 || (halt_from >= 0 && cyc > halt_from + 4)) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        case ($urandom_range(0, 5))
          0: a = 12'h105;
          1: a = 12'h140;
          2: a = 12'h141;
          3: a = 12'h142;
          4: a = 12'h000;
          default: a = 12'h7FF;
        endcase
        step($urandom_range(0, 9) == 0, $urandom, {$urandom, $urandom} & ~64'h3,
             $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, a,
             {$urandom, $urandom});
      end
    end

    repeat (6) idle_step(12'h140);
    chk("pending_redirects", 64'(rq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
